// File: rtl/fp_pkg.sv
// Shared types for the fixed-point unit initiator: word format, opcodes,
// FSM states and the queued command record.
package fp_pkg;

  localparam int N = 32;
  localparam int Q = 15;

  typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL, OP_DIV} fp_op_e;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  typedef struct packed {
    logic [N-1:0] a;
    logic [N-1:0] b;
    fp_op_e       op;
  } fp_cmd_t;

endpackage

// File: rtl/fp_cmd_fifo.sv
// Synchronous command FIFO. Flags come from the registered count only, so
// a full FIFO stays full for the cycle in which it is also popped.
module fp_cmd_fifo
  import fp_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push,
  input  logic    pop,
  input  fp_cmd_t wr_data,
  output fp_cmd_t rd_data,
  output logic    full,
  output logic    empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  fp_cmd_t       mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  // Pointers are exactly log2(DEPTH) bits, so they wrap without extra logic.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/fp_op_initiator.sv
// Drives the fixed-point unit's slave port: queues host requests, launches one
// operation at a time, waits for done_flag or timeout, returns the result.
//
// Handshakes: a transfer happens on a rising clock edge where valid and ready
// are both high; once raised, valid and its payload hold until that edge.
module fp_op_initiator
  import fp_pkg::*;
#(
  parameter int CMD_DEPTH = 4,
  parameter int TIMEOUT   = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [N-1:0] req_a,
  input  logic [N-1:0] req_b,
  input  logic [1:0]   req_op,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [N-1:0] rsp_c,
  output logic         rsp_timeout,
  output logic [N-1:0] a,
  output logic [N-1:0] b,
  output logic [1:0]   opcode,
  output logic         start,
  input  logic [N-1:0] c,
  input  logic         done_flag
);

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  state_e      state_q;
  state_e      state_d;
  logic        pop;
  logic        fifo_full;
  logic        fifo_empty;
  fp_cmd_t     req_cmd;
  fp_cmd_t     head;
  logic [15:0] wait_cnt;

  assign req_cmd   = '{a: req_a, b: req_b, op: fp_op_e'(req_op)};
  assign req_ready = !rst && !fifo_full;

  fp_cmd_fifo #(.DEPTH(CMD_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (req_valid && req_ready),
    .pop     (pop),
    .wr_data (req_cmd),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (done_flag || wait_cnt == TO_LAST) state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_d = ISSUE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // done_flag is only honoured in WAIT; an ISSUE-cycle pulse is a stale leftover.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      wait_cnt    <= '0;
      a           <= '0;
      b           <= '0;
      opcode      <= '0;
      rsp_c       <= '0;
      rsp_timeout <= 1'b0;
    end else begin
      state_q <= state_d;
      if (pop) begin
        a      <= head.a;
        b      <= head.b;
        opcode <= head.op;
      end
      if (state_q == ISSUE) begin
        wait_cnt <= '0;
      end else if (state_q == WAIT && !done_flag && wait_cnt != TO_LAST) begin
        wait_cnt <= wait_cnt + 16'd1;
      end
      if (state_q == WAIT) begin
        if (done_flag) begin
          rsp_c       <= c;
          rsp_timeout <= 1'b0;
        end else if (wait_cnt == TO_LAST) begin
          rsp_c       <= '0;
          rsp_timeout <= 1'b1;
        end
      end
    end
  end

  assign start     = (state_q == ISSUE);
  assign rsp_valid = (state_q == RESP);

endmodule

// File: tb/tb_fp_op_initiator.sv
// Directed-plus-random bench for fp_op_initiator with an emulated arithmetic
// unit and queue-based expectations for issue order, latency and results.
module tb_fp_op_initiator;
  import fp_pkg::*;

  localparam int DEPTH = 4;
  localparam int TMO   = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid;
  logic         req_ready;
  logic [N-1:0] req_a;
  logic [N-1:0] req_b;
  logic [1:0]   req_op;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [N-1:0] rsp_c;
  logic         rsp_timeout;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic [1:0]   opcode;
  logic         start;
  logic [N-1:0] c;
  logic         done_flag;

  fp_op_initiator #(.CMD_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_op      (req_op),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_c       (rsp_c),
    .rsp_timeout (rsp_timeout),
    .a           (a),
    .b           (b),
    .opcode      (opcode),
    .start       (start),
    .c           (c),
    .done_flag   (done_flag)
  );

  // ---------------- clock / cycle count ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- bench state ----------------
  int n_cmp = 0;
  int n_err = 0;

  logic [65:0] cmd_q[$];      // {a, b, op} accepted, not yet issued
  logic [32:0] exp_q[$];      // {timeout, c} expected responses in order
  int          exp_cyc_q[$];  // cycle in which rsp_valid must rise

  int          rsp_mode = 0;  // 0 low, 1 high, 2 random
  int          unit_lat = 3;  // 0 = unit never answers
  bit          unit_rand = 1'b0;
  bit          c_rand = 1'b1;
  bit          stale = 1'b0;
  logic [31:0] fixed_c = '0;

  int          unit_rem = 0;
  logic [31:0] unit_cval = '0;
  logic [65:0] cur_cmd = '0;
  bit          unit_busy = 1'b0;
  logic        prev_start = 1'b0;
  int          start_cnt = 0;
  int          last_start_cyc = 0;

  bit          prev_valid = 1'b0;
  int          rise_cnt = 0;
  int          hs_cnt = 0;
  logic [31:0] last_c = '0;
  logic        last_tmo = 1'b0;
  int          last_acc_cyc = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- emulated arithmetic unit ----------------
  always @(negedge clk) begin
    int lat;
    done_flag = 1'b0;
    c = $urandom;
    if (rst === 1'b1) unit_busy = 1'b0;
    if (unit_rem > 0) begin
      unit_rem--;
      if (unit_rem == 0) begin
        done_flag = 1'b1;
        c = unit_cval;
      end
    end
    if (start === 1'b1) begin
      start_cnt++;
      last_start_cyc = cyc;
      check("start_width", 32'(prev_start), 32'd0);
      check("issue_while_rsp", 32'(rsp_valid), 32'd0);
      if (cmd_q.size() == 0) begin
        check("start_unexpected", 32'd1, 32'd0);
      end else begin
        cur_cmd = cmd_q.pop_front();
        check("issue_a", a, cur_cmd[65:34]);
        check("issue_b", b, cur_cmd[33:2]);
        check("issue_op", 32'(opcode), 32'(cur_cmd[1:0]));
      end
      lat = unit_rand ? int'($urandom_range(1, 6)) : unit_lat;
      unit_cval = c_rand ? $urandom : fixed_c;
      unit_rem = lat;
      exp_cyc_q.push_back(lat == 0 ? cyc + TMO + 1 : cyc + lat + 1);
      exp_q.push_back(lat == 0 ? {1'b1, 32'h0} : {1'b0, unit_cval});
      if (stale) done_flag = 1'b1;
      unit_busy = 1'b1;
    end else if (unit_busy) begin
      check("hold_a", a, cur_cmd[65:34]);
      check("hold_b", b, cur_cmd[33:2]);
      check("hold_op", 32'(opcode), 32'(cur_cmd[1:0]));
    end
    prev_start = start;
  end

  // ---------------- response scoreboard ----------------
  always @(negedge clk) begin
    if (rsp_valid === 1'b1 && !prev_valid) begin
      rise_cnt++;
      if (exp_cyc_q.size() == 0) check("rsp_unexpected", 32'd1, 32'd0);
      else check("rsp_latency", 32'(cyc), 32'(exp_cyc_q.pop_front()));
    end
    if (rsp_valid === 1'b1 && exp_q.size() != 0) begin
      check("rsp_c", rsp_c, exp_q[0][31:0]);
      check("rsp_timeout", 32'(rsp_timeout), 32'(exp_q[0][32]));
      if (rsp_ready === 1'b1) begin
        last_c   = rsp_c;
        last_tmo = rsp_timeout;
        void'(exp_q.pop_front());
        hs_cnt++;
      end
    end
    prev_valid = (rsp_valid === 1'b1);
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    if (rsp_mode == 2) rsp_ready = 1'($urandom_range(0, 1));
    else rsp_ready = (rsp_mode == 1);
  endtask

  task automatic set_rsp_mode(input int m);
    rsp_mode  = m;
    rsp_ready = (m == 1);
  endtask

  task automatic push(input logic [31:0] pa, input logic [31:0] pb, input logic [1:0] po);
    int n = 0;
    req_valid = 1'b1;
    req_a = pa;
    req_b = pb;
    req_op = po;
    while (req_ready !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    check("push_bound", 32'(n < 200), 32'd1);
    last_acc_cyc = cyc;
    cmd_q.push_back({pa, pb, po});
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_rsps(input int target);
    int n = 0;
    while (hs_cnt < target && n < 1000) begin
      tick();
      n++;
    end
    check("wait_rsps_bound", 32'(hs_cnt), 32'(target));
  endtask

  task automatic wait_valid();
    int n = 0;
    while (rsp_valid !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    check("wait_valid_bound", 32'(rsp_valid), 32'd1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int          s0;
    int          r0;
    logic [31:0] va;

    rst = 1'b1;
    req_valid = 1'b0;
    req_a = '0;
    req_b = '0;
    req_op = '0;
    rsp_ready = 1'b0;
    done_flag = 1'b0;
    c = '0;

    // Reset state
    tick();
    tick();
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_start", 32'(start), 32'd0);
    check("rst_a", a, 32'd0);
    check("rst_rsp_c", rsp_c, 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_req_ready", 32'(req_ready), 32'd1);

    // Single op: 1.5 + 2.25, unit answers 3.75 three cycles after start
    set_rsp_mode(1);
    c_rand = 1'b0;
    fixed_c = 32'h0001_E000;
    unit_lat = 3;
    s0 = start_cnt;
    push(32'h0000_C000, 32'h0001_2000, 2'b00);
    wait_rsps(1);
    check("single_start_cnt", 32'(start_cnt), 32'(s0 + 1));
    check("single_start_cyc", 32'(last_start_cyc), 32'(last_acc_cyc + 2));
    check("single_c", last_c, 32'h0001_E000);
    check("single_tmo", 32'(last_tmo), 32'd0);

    // Backpressure + timeout: unit stalled, response held unconsumed
    c_rand = 1'b1;
    unit_lat = 0;
    set_rsp_mode(0);
    push($urandom, $urandom, 2'b01);
    wait_valid();
    for (int i = 0; i < 4; i++) push($urandom, $urandom, 2'($urandom_range(0, 3)));
    check("bp_ready_low", 32'(req_ready), 32'd0);
    s0 = start_cnt;
    va = $urandom;
    req_valid = 1'b1;
    req_a = va;
    req_b = ~va;
    req_op = 2'b11;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_hold_valid", 32'(rsp_valid), 32'd1);
      check("bp_hold_ready", 32'(req_ready), 32'd0);
      check("bp_no_start", 32'(start_cnt), 32'(s0));
    end
    unit_lat = 2;
    set_rsp_mode(1);
    push(va, ~va, 2'b11);
    check("tmo_flag", 32'(last_tmo), 32'd1);
    check("tmo_c", last_c, 32'd0);
    wait_rsps(7);
    check("after_tmo_normal", 32'(last_tmo), 32'd0);

    // Stale done during ISSUE must be ignored
    stale = 1'b1;
    c_rand = 1'b0;
    fixed_c = $urandom;
    unit_lat = 3;
    push($urandom, $urandom, 2'b10);
    wait_rsps(8);
    stale = 1'b0;
    check("stale_c", last_c, fixed_c);
    check("stale_tmo", 32'(last_tmo), 32'd0);

    // Reset two cycles into WAIT with two ops queued
    c_rand = 1'b1;
    unit_lat = 6;
    for (int i = 0; i < 3; i++) push($urandom, $urandom, 2'($urandom_range(0, 3)));
    tick();
    rst = 1'b1;
    tick();
    check("mid_rst_req_ready", 32'(req_ready), 32'd0);
    check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("mid_rst_rsp_c", rsp_c, 32'd0);
    check("mid_rst_rsp_tmo", 32'(rsp_timeout), 32'd0);
    check("mid_rst_a", a, 32'd0);
    check("mid_rst_b", b, 32'd0);
    check("mid_rst_op", 32'(opcode), 32'd0);
    check("mid_rst_start", 32'(start), 32'd0);
    rst = 1'b0;
    cmd_q.delete();
    exp_q.delete();
    exp_cyc_q.delete();
    s0 = start_cnt;
    r0 = rise_cnt;
    for (int i = 0; i < 12; i++) tick();
    check("post_rst_no_start", 32'(start_cnt), 32'(s0));
    check("post_rst_no_rsp", 32'(rise_cnt), 32'(r0));
    check("post_rst_ready", 32'(req_ready), 32'd1);

    // Wrap-around: 12 ops, random latency and random response backpressure
    r0 = hs_cnt;
    unit_rand = 1'b1;
    set_rsp_mode(2);
    for (int i = 0; i < 12; i++) begin
      va = (i == 0) ? 32'h8000_8000 : $urandom;
      push(va, $urandom, 2'($urandom_range(0, 3)));
    end
    wait_rsps(r0 + 12);
    check("wrap_exp_empty", 32'(exp_q.size()), 32'd0);
    check("wrap_cmd_empty", 32'(cmd_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
